tail_light_sequencer: RTL and testbench
=======================================

Name: tail_light_sequencer

Overview:
- Mode arbiter and pattern scheduler for the six-lamp tail-light datapath on the DE10-Lite board.
- Takes the hazard, turn, direction and brake requests from the board switches and keys, and resolves them by fixed priority into a single lamp mode.
- Drives the chase and blink sequencing on LEDR from an internal prescaled step tick, and shows the active mode code on HEX0.

Parameters:
- TICK_DIV, 2500000, ADC_CLK_10 cycles per pattern step (4 Hz at 10 MHz). Legal range is 2 or more. Simulation uses 4.
- CNT_W, 22, prescaler counter width. Must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- ADC_CLK_10  in   1   system clock, rising edge only.
- KEY         in   2   KEY[0]: synchronous active-low reset. KEY[1]: turn direction, 0=right, 1=left.
- SW          in   10  SW[0]=hazard, SW[1]=turn enable, SW[2]=brake. SW[9:3] ignored.
- LEDR        out  10  lamps. LEDR[2:0]=right side (LEDR[0] innermost). LEDR[9:7]=left side (LEDR[7] innermost). LEDR[6:3] status.
- HEX0        out  8   active-low 7-seg, bit7=DP (always 1, off).

Behaviour:
- Reset: KEY[0]=0 sampled at a rising edge clears every register.
  - Synchronizers=0, mode=IDLE, phase=0, prescaler=0, LEDR=10'h000, HEX0=8'hC0.
  - Reset held keeps these values. Reset mid-sequence aborts the sequence immediately.
- KEY[0] itself is not synchronized. SW[2:0] and KEY[1] each pass through a 2-flop synchronizer.
- Mode arbitration, from synchronized requests, highest priority first:
  - HAZ (6): hazard=1; turn and brake are ignored.
  - BRK_L (5) / BRK_R (4): brake=1 and turn=1.
  - BRK (3): brake=1 only.
  - TURN_L (2) / TURN_R (1): turn=1 only.
  - IDLE (0): nothing requested.
- Mode register updates every cycle.
- When the arbitrated mode differs from the current mode, at that same edge:
  - mode loads the new value;
  - phase clears to 0;
  - prescaler clears to 0.
- A direction flip during a turn counts as a mode change.
- Latency: a SW/KEY[1] change set up before edge E1 appears on LEDR and HEX0 after edge E3.
- Prescaler: counts 0..TICK_DIV-1.
  - At an edge where count==TICK_DIV-1 and the mode does not change: count->0 and phase increments (2-bit, 3 wraps to 0).
  - A mode change on the same edge wins: phase=0, count=0.
- Net effect: the pattern advances every TICK_DIV edges, starting TICK_DIV edges after the mode load.
- LEDR and HEX0 are registered and load the pattern for the updated mode and phase at the same edge.
- Chase pattern C(p), innermost lamp first: p0=001, p1=011, p2=111, p3=000.
  - Applied to LEDR[2:0] as written.
  - Applied to LEDR[9:7] bit-reversed: p0=100, p1=110, p2=111, p3=000.
- Lamp patterns by mode:
  - IDLE: all lamps 0.
  - TURN_R: right side = C(phase), left side = 000.
  - TURN_L: left side = C(phase), right side = 000.
  - BRK: both sides 111, steady.
  - BRK_R: right side = C(phase), left side = 111.
  - BRK_L: left side = C(phase), right side = 111.
  - HAZ: both sides 111 when phase[0]=0, 000 when phase[0]=1.
- LEDR[6:3]=0 except as given under Optional Feature.
- HEX0 mode digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82.
- HEX0 does not change with phase.

Optional Feature:
- Macro TLS_HEARTBEAT_EN.
- Defined: LEDR[3] toggles at every tick edge in all modes, including IDLE. It resets to 0 and is not cleared by a mode change.
- Undefined: LEDR[3] is tied to 0, and the heartbeat flop is not present.

Test Plan:
All cases use TICK_DIV=4 and CNT_W=3.
- Reset: KEY=2'b00 for 3 edges with SW=10'h007 -> LEDR=000, HEX0=C0. Release -> HAZ after 3 edges: LEDR=10'h387, HEX0=82.
- Right turn: SW=10'h002, KEY=2'b01.
  - LEDR[2:0]=001 after E3, then 011 at E7, 111 at E11, 000 at E15, 001 at E19.
  - LEDR[9:7]=000 throughout; HEX0=F9.
- Left turn, then direction flip mid-sequence:
  - SW=10'h002, KEY=2'b11 -> LEDR[9:7]=100, 110, 111; HEX0=A4.
  - Drop KEY[1] at phase 2 -> 3 edges later LEDR[2:0]=001, LEDR[9:7]=000, phase restarted.
- Brake plus turn: SW=10'h006, KEY=2'b11 -> LEDR[2:0]=111 steady while the left side chases; HEX0=92. Drop SW[1] -> LEDR=10'h387 steady, HEX0=B0.
- Hazard priority: SW=10'h007 -> LEDR alternates 10'h387 / 10'h000 every 4 edges; HEX0=82. SW[9:3] toggling has no effect.
- Idle and heartbeat: SW=10'h000 -> LEDR[9:7]=LEDR[2:0]=0, HEX0=C0. With TLS_HEARTBEAT_EN, LEDR[3] toggles every 4 edges; without it, LEDR[3]=0.

Source files
------------

// File: rtl/tail_light_sequencer_if.sv
// Board-side bundle for the tail-light sequencer: key/switch requests in, lamp and 7-seg drive out.
interface tail_light_sequencer_if;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [7:0] HEX0;

    modport master (output KEY, output SW, input LEDR, input HEX0);
    modport slave  (input KEY, input SW, output LEDR, output HEX0);
endinterface

// File: rtl/tail_light_sequencer.sv
// Priority mode arbiter and chase/blink scheduler for the six tail lamps, with mode code on HEX0.
// Optional heartbeat on LEDR[3] is enabled by defining TLS_HEARTBEAT_EN.
module tail_light_sequencer #(
    parameter int unsigned TICK_DIV = 2500000,
    parameter int unsigned CNT_W    = 22
) (
    input  logic                  ADC_CLK_10,
    tail_light_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_R = 3'd1,
        TURN_L = 3'd2,
        BRK    = 3'd3,
        BRK_R  = 3'd4,
        BRK_L  = 3'd5,
        HAZ    = 3'd6
    } mode_e;

    logic             w_rst_n;
    logic             w_unused;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tick;
    logic [2:0]       w_chase;
    logic [5:0]       w_lamps_nxt;
    logic [5:0]       r_lamps;
    logic [7:0]       w_hex_nxt;
    logic [7:0]       r_hex;
    logic             w_hb;

    assign w_rst_n  = bus.KEY[0];
    assign w_unused = ^bus.SW[9:3];

    // Chase pattern, innermost lamp in bit 0.
    function automatic logic [2:0] chase(input logic [1:0] p);
        case (p)
            2'd0:    chase = 3'b001;
            2'd1:    chase = 3'b011;
            2'd2:    chase = 3'b111;
            default: chase = 3'b000;
        endcase
    endfunction

    // Request synchronizers, packed as {dir, brake, turn, hazard}.
    always_ff @(posedge ADC_CLK_10) begin
        if (!w_rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= {bus.KEY[1], bus.SW[2:0]};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (!w_rst_n) begin
            r_mode  <= IDLE;
            r_phase <= 2'd0;
            r_cnt   <= '0;
            r_lamps <= 6'b000000;
            r_hex   <= 8'hC0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lamps <= w_lamps_nxt;
            r_hex   <= w_hex_nxt;
        end
    end

    // Arbitration, prescaler/phase sequencing and output pattern for the next state.
    always_comb begin
        w_mode_nxt  = IDLE;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_phase_nxt = r_phase;
        w_lamps_nxt = 6'b000000;
        w_hex_nxt   = 8'hC0;
        w_tick      = (r_cnt == CNT_W'(TICK_DIV - 1));

        if (r_sync2[0])
            w_mode_nxt = HAZ;
        else if (r_sync2[2] && r_sync2[1])
            w_mode_nxt = r_sync2[3] ? BRK_L : BRK_R;
        else if (r_sync2[2])
            w_mode_nxt = BRK;
        else if (r_sync2[1])
            w_mode_nxt = r_sync2[3] ? TURN_L : TURN_R;

        // A mode change restarts the sequence even on a tick edge.
        if (w_mode_nxt != r_mode) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 2'd0;
        end else if (w_tick) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = r_phase + 2'd1;
        end

        // Lamps are {left[9:7], right[2:0]}; left side is the bit-reversed chase.
        w_chase = chase(w_phase_nxt);
        case (w_mode_nxt)
            TURN_R: begin
                w_lamps_nxt = {3'b000, w_chase};
                w_hex_nxt   = 8'hF9;
            end
            TURN_L: begin
                w_lamps_nxt = {w_chase[0], w_chase[1], w_chase[2], 3'b000};
                w_hex_nxt   = 8'hA4;
            end
            BRK: begin
                w_lamps_nxt = 6'b111111;
                w_hex_nxt   = 8'hB0;
            end
            BRK_R: begin
                w_lamps_nxt = {3'b111, w_chase};
                w_hex_nxt   = 8'h99;
            end
            BRK_L: begin
                w_lamps_nxt = {w_chase[0], w_chase[1], w_chase[2], 3'b111};
                w_hex_nxt   = 8'h92;
            end
            HAZ: begin
                w_lamps_nxt = w_phase_nxt[0] ? 6'b000000 : 6'b111111;
                w_hex_nxt   = 8'h82;
            end
            default: begin
                w_lamps_nxt = 6'b000000;
                w_hex_nxt   = 8'hC0;
            end
        endcase
    end

`ifdef TLS_HEARTBEAT_EN
    logic r_hb;

    // Free-running toggle on every prescaler wrap, independent of mode.
    always_ff @(posedge ADC_CLK_10) begin
        if (!w_rst_n)
            r_hb <= 1'b0;
        else if (w_tick)
            r_hb <= ~r_hb;
    end

    assign w_hb = r_hb;
`else
    assign w_hb = 1'b0;
`endif

    assign bus.LEDR = {r_lamps[5:3], 3'b000, w_hb, r_lamps[2:0]};
    assign bus.HEX0 = r_hex;
endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed self-checking bench for tail_light_sequencer with TICK_DIV=4, CNT_W=3.
module tb_tail_light_sequencer;
    localparam logic [9:0] LAMP_MASK = 10'h3F7;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    tail_light_sequencer_if u_if();

    tail_light_sequencer #(.TICK_DIV(4), .CNT_W(3)) u_dut (
        .ADC_CLK_10 (clk),
        .bus        (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [9:0] sw, input logic dir);
        u_if.SW  = sw;
        u_if.KEY = {dir, 1'b0};
        step(3);
        u_if.KEY = {dir, 1'b1};
    endtask

    task automatic test_reset;
        apply_reset(10'h007, 1'b0);
        n_tests++;
        if (u_if.LEDR !== 10'h000) begin n_fail++; $display("FAIL reset_ledr: got %h expected %h", u_if.LEDR, 10'h000); end
        n_tests++;
        if (u_if.HEX0 !== 8'hC0) begin n_fail++; $display("FAIL reset_hex: got %h expected %h", u_if.HEX0, 8'hC0); end
        step(2);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h000) begin n_fail++; $display("FAIL reset_latency: got %h expected %h", u_if.LEDR, 10'h000); end
        step(1);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h387) begin n_fail++; $display("FAIL reset_haz_ledr: got %h expected %h", u_if.LEDR, 10'h387); end
        n_tests++;
        if (u_if.HEX0 !== 8'h82) begin n_fail++; $display("FAIL reset_haz_hex: got %h expected %h", u_if.HEX0, 8'h82); end
    endtask

    task automatic test_right_turn;
        logic [9:0] exp_l [5];
        exp_l = '{10'h001, 10'h003, 10'h007, 10'h000, 10'h001};
        apply_reset(10'h002, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i == 0 ? 3 : 4);
            n_tests++;
            if ((u_if.LEDR & LAMP_MASK) !== exp_l[i]) begin n_fail++; $display("FAIL right_turn_p%0d: got %h expected %h", i, u_if.LEDR, exp_l[i]); end
            n_tests++;
            if (u_if.HEX0 !== 8'hF9) begin n_fail++; $display("FAIL right_turn_hex_p%0d: got %h expected %h", i, u_if.HEX0, 8'hF9); end
        end
    endtask

    task automatic test_left_flip;
        logic [9:0] exp_l [3];
        exp_l = '{10'h200, 10'h300, 10'h380};
        apply_reset(10'h002, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i == 0 ? 3 : 4);
            n_tests++;
            if ((u_if.LEDR & LAMP_MASK) !== exp_l[i]) begin n_fail++; $display("FAIL left_turn_p%0d: got %h expected %h", i, u_if.LEDR, exp_l[i]); end
            n_tests++;
            if (u_if.HEX0 !== 8'hA4) begin n_fail++; $display("FAIL left_turn_hex_p%0d: got %h expected %h", i, u_if.HEX0, 8'hA4); end
        end
        u_if.KEY = 2'b01;
        step(2);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h380) begin n_fail++; $display("FAIL flip_latency: got %h expected %h", u_if.LEDR, 10'h380); end
        step(1);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h001) begin n_fail++; $display("FAIL flip_restart: got %h expected %h", u_if.LEDR, 10'h001); end
        n_tests++;
        if (u_if.HEX0 !== 8'hF9) begin n_fail++; $display("FAIL flip_hex: got %h expected %h", u_if.HEX0, 8'hF9); end
        step(4);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h003) begin n_fail++; $display("FAIL flip_p1: got %h expected %h", u_if.LEDR, 10'h003); end
    endtask

    task automatic test_brake_turn;
        logic [9:0] exp_l [3];
        exp_l = '{10'h207, 10'h307, 10'h387};
        apply_reset(10'h006, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i == 0 ? 3 : 4);
            n_tests++;
            if ((u_if.LEDR & LAMP_MASK) !== exp_l[i]) begin n_fail++; $display("FAIL brake_left_p%0d: got %h expected %h", i, u_if.LEDR, exp_l[i]); end
            n_tests++;
            if (u_if.HEX0 !== 8'h92) begin n_fail++; $display("FAIL brake_left_hex_p%0d: got %h expected %h", i, u_if.HEX0, 8'h92); end
        end
        u_if.SW = 10'h004;
        step(3);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h387) begin n_fail++; $display("FAIL brake_only: got %h expected %h", u_if.LEDR, 10'h387); end
        n_tests++;
        if (u_if.HEX0 !== 8'hB0) begin n_fail++; $display("FAIL brake_only_hex: got %h expected %h", u_if.HEX0, 8'hB0); end
        step(4);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h387) begin n_fail++; $display("FAIL brake_steady: got %h expected %h", u_if.LEDR, 10'h387); end
        apply_reset(10'h006, 1'b0);
        step(3);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h381) begin n_fail++; $display("FAIL brake_right: got %h expected %h", u_if.LEDR, 10'h381); end
        n_tests++;
        if (u_if.HEX0 !== 8'h99) begin n_fail++; $display("FAIL brake_right_hex: got %h expected %h", u_if.HEX0, 8'h99); end
        step(4);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h383) begin n_fail++; $display("FAIL brake_right_p1: got %h expected %h", u_if.LEDR, 10'h383); end
    endtask

    task automatic test_hazard;
        logic [9:0] exp_l [5];
        exp_l = '{10'h387, 10'h000, 10'h387, 10'h000, 10'h387};
        apply_reset(10'h007, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) u_if.SW = 10'h3FF;
            if (i == 3) u_if.SW = 10'h1A7;
            step(i == 0 ? 3 : 4);
            n_tests++;
            if ((u_if.LEDR & LAMP_MASK) !== exp_l[i]) begin n_fail++; $display("FAIL hazard_p%0d: got %h expected %h", i, u_if.LEDR, exp_l[i]); end
            n_tests++;
            if (u_if.HEX0 !== 8'h82) begin n_fail++; $display("FAIL hazard_hex_p%0d: got %h expected %h", i, u_if.HEX0, 8'h82); end
        end
    endtask

    task automatic test_idle_heartbeat;
        apply_reset(10'h000, 1'b0);
        step(3);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h000) begin n_fail++; $display("FAIL idle_ledr: got %h expected %h", u_if.LEDR, 10'h000); end
        n_tests++;
        if (u_if.HEX0 !== 8'hC0) begin n_fail++; $display("FAIL idle_hex: got %h expected %h", u_if.HEX0, 8'hC0); end
`ifdef TLS_HEARTBEAT_EN
        n_tests++;
        if (u_if.LEDR[3] !== 1'b0) begin n_fail++; $display("FAIL hb_r3: got %b expected %b", u_if.LEDR[3], 1'b0); end
        step(1);
        n_tests++;
        if (u_if.LEDR[3] !== 1'b1) begin n_fail++; $display("FAIL hb_r4: got %b expected %b", u_if.LEDR[3], 1'b1); end
        step(3);
        n_tests++;
        if (u_if.LEDR[3] !== 1'b1) begin n_fail++; $display("FAIL hb_r7: got %b expected %b", u_if.LEDR[3], 1'b1); end
        step(1);
        n_tests++;
        if (u_if.LEDR[3] !== 1'b0) begin n_fail++; $display("FAIL hb_r8: got %b expected %b", u_if.LEDR[3], 1'b0); end
`else
        for (int i = 0; i < 3; i++) begin
            step(3);
            n_tests++;
            if (u_if.LEDR[3] !== 1'b0) begin n_fail++; $display("FAIL hb_tied_%0d: got %b expected %b", i, u_if.LEDR[3], 1'b0); end
        end
`endif
        step(1);
        n_tests++;
        if ((u_if.LEDR & LAMP_MASK) !== 10'h000) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", u_if.LEDR, 10'h000); end
    endtask

    initial begin
        u_if.KEY = 2'b00;
        u_if.SW  = 10'h000;
        test_reset();
        test_right_turn();
        test_left_flip();
        test_brake_turn();
        test_hazard();
        test_idle_heartbeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
